// File: rtl/cpu_sequencer.sv
// Program sequencer for the 4-bit ALU/register datapath: fetches 8-bit words
// from a combinational ROM, decodes OP/JMP/JC/HALT and handles run/single-step.
module cpu_sequencer #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step_mode,
   input  logic              step,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   input  logic              carry_in,
   output logic              load,
   output logic              mux_sel,
   output logic [1:0]        alu_sel,
   output logic [ADDR_W-1:0] pc_out,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_WAIT   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   localparam logic [1:0]       OP_ALU  = 2'b00;
   localparam logic [1:0]       OP_JMP  = 2'b01;
   localparam logic [1:0]       OP_JC   = 2'b10;
   localparam logic [1:0]       OP_HALT = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [7:0]          ir;
   logic                carry_flag;
   logic [CNT_W-1:0]    cnt;

   logic [1:0]          op;
   logic [ADDR_W-1:0]   target;
   logic [ADDR_W-1:0]   pc_inc;
   logic                exec_alu;

   assign op       = ir[7:6];
   assign target   = ir[ADDR_W-1:0];
   assign pc_inc   = pc + ADDR_W'(1);
   assign exec_alu = (state == S_EXEC) && (op == OP_ALU);

   // Datapath controls are decoded straight from ir so the register loads on the edge ending EXEC.
   assign load      = exec_alu & ir[0];
   assign mux_sel   = exec_alu & ir[1];
   assign alu_sel   = exec_alu ? ir[3:2] : 2'b00;

   assign rom_addr  = pc;
   assign pc_out    = pc;
   assign instr_cnt = cnt;
   assign busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_WAIT);
   assign halted    = (state == S_HALTED);

   // Sequencer state, program counter, instruction register, carry flag and retire counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= '0;
         ir         <= '0;
         carry_flag <= 1'b0;
         cnt        <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  state      <= S_FETCH;
                  pc         <= '0;
                  carry_flag <= 1'b0;
                  cnt        <= '0;
               end
            end
            S_FETCH: begin
               ir    <= rom_data;
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
               unique case (op)
                  OP_ALU: begin
                     pc <= pc_inc;
                     if (ir[0]) carry_flag <= carry_in;
                  end
                  OP_JMP:  pc <= target;
                  OP_JC:   pc <= carry_flag ? target : pc_inc;
                  default: pc <= pc;
               endcase
               if (op == OP_HALT)  state <= S_HALTED;
               else if (step_mode) state <= S_WAIT;
               else                state <= S_FETCH;
            end
            // WAIT is only entered with step_mode set, so a step here always releases it.
            S_WAIT: begin
               if (step) state <= S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: program vector table, hand-written
// corner sequences and random programs against an instruction-level model.
module tb_cpu_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       step_mode;
   logic       step;
   logic [2:0] rom_addr;
   logic [7:0] rom_data;
   logic       carry_in;
   logic       load;
   logic       mux_sel;
   logic [1:0] alu_sel;
   logic [2:0] pc_out;
   logic       busy;
   logic       halted;
   logic [7:0] instr_cnt;

   logic [7:0] rom [8];
   assign rom_data = rom[rom_addr];

   int n_cmp  = 0;
   int n_fail = 0;

   cpu_sequencer #(.ADDR_W(3), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .step_mode (step_mode),
      .step      (step),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .carry_in  (carry_in),
      .load      (load),
      .mux_sel   (mux_sel),
      .alu_sel   (alu_sel),
      .pc_out    (pc_out),
      .busy      (busy),
      .halted    (halted),
      .instr_cnt (instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] prog;
      logic        carry;
      int          ticks;
      logic [2:0]  pc;
      logic [7:0]  cnt;
      logic        halted;
      logic        busy;
      int          loads;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rom(input logic [63:0] p);
      for (int i = 0; i < 8; i++) rom[i] = p[8*i +: 8];
   endtask

   task automatic reset_dut();
      rst = 1'b1; start = 1'b0; step = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic start_dut();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   vec_t        vecs [7];
   logic [2:0]  mpc;
   logic        mflag;
   int          mcnt;
   logic        mdone;
   logic [7:0]  w;
   logic [3:0]  exp_ctl;
   int          nloads;

   initial begin
      rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; carry_in = 1'b0;
      load_rom(64'h0);

      // Reset state
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_cnt", instr_cnt, 0);
      chk("rst_ctl", {alu_sel, mux_sel, load}, 0);
      tick();
      chk("idle_holds", busy, 0);

      // prog, carry, ticks after start, pc, cnt, halted, busy, load cycles
      vecs[0] = '{64'h0000_0000_00C0_0501, 1'b0, 6,  3'd2, 8'd3, 1'b1, 1'b0, 2}; // run + halt
      vecs[1] = '{64'h0000_0000_0000_0000, 1'b0, 16, 3'd0, 8'd8, 1'b0, 1'b1, 0}; // wrap
      vecs[2] = '{64'h00C0_0000_00C0_8601, 1'b1, 6,  3'd6, 8'd3, 1'b1, 1'b0, 1}; // JC taken
      vecs[3] = '{64'h00C0_0000_00C0_8601, 1'b0, 6,  3'd2, 8'd3, 1'b1, 1'b0, 1}; // JC not taken
      vecs[4] = '{64'h00C0_0000_00C0_8600, 1'b1, 6,  3'd2, 8'd3, 1'b1, 1'b0, 0}; // no load, flag stays 0
      vecs[5] = '{64'h0000_0000_0000_0040, 1'b0, 10, 3'd0, 8'd5, 1'b0, 1'b1, 0}; // JMP self
      vecs[6] = '{64'h0000_C000_0000_007D, 1'b0, 4,  3'd5, 8'd2, 1'b1, 1'b0, 0}; // JMP high bits ignored

      for (int i = 0; i < 7; i++) begin
         load_rom(vecs[i].prog);
         carry_in  = vecs[i].carry;
         step_mode = 1'b0;
         reset_dut();
         start_dut();
         nloads = 0;
         for (int t = 0; t < vecs[i].ticks; t++) begin
            tick();
            if (load === 1'b1) nloads++;
         end
         chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].pc);
         chk($sformatf("vec%0d_cnt", i), instr_cnt, vecs[i].cnt);
         chk($sformatf("vec%0d_halted", i), halted, vecs[i].halted);
         chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
         chk($sformatf("vec%0d_loads", i), nloads, vecs[i].loads);
      end
      carry_in = 1'b0;

      // Full decode of an ALU word, and no controls for a JMP with low bits set
      load_rom(64'h0000_0000_0000_4F0F);
      reset_dut(); start_dut();
      tick();
      chk("dec_alu", {alu_sel, mux_sel, load}, 4'hF);
      tick(); tick();
      chk("dec_jmp", {alu_sel, mux_sel, load}, 0);

      // Step mode: parks in WAIT, one instruction per step pulse
      load_rom(64'h0);
      step_mode = 1'b1;
      reset_dut(); start_dut();
      tick(); tick();
      chk("step_wait_pc", pc_out, 1);
      chk("step_wait_busy", busy, 1);
      repeat (5) tick();
      chk("step_hold_pc", pc_out, 1);
      chk("step_hold_cnt", instr_cnt, 1);
      chk("step_hold_ctl", {alu_sel, mux_sel, load}, 0);
      step = 1'b1; tick(); step = 1'b0;
      tick(); tick();
      chk("step_one_pc", pc_out, 2);
      chk("step_one_cnt", instr_cnt, 2);
      repeat (3) tick();
      chk("step_one_hold", pc_out, 2);
      step_mode = 1'b0;

      // Misuse: start and step while running are ignored
      reset_dut(); start_dut();
      repeat (3) tick();
      start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
      tick();
      chk("misuse_pc", pc_out, 2);
      chk("misuse_cnt", instr_cnt, 2);
      chk("misuse_busy", busy, 1);

      // Reset during EXEC of a loading OP
      load_rom(64'h0101_0101_0101_0101);
      reset_dut(); start_dut();
      repeat (3) tick();
      chk("mid_exec_load", load, 1);
      chk("mid_exec_cnt", instr_cnt, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_exec_busy", busy, 0);
      chk("rst_exec_pc", pc_out, 0);
      chk("rst_exec_cnt", instr_cnt, 0);
      chk("rst_exec_ctl", {halted, alu_sel, mux_sel, load}, 0);

      // Restart from HALTED clears pc and counter
      load_rom(64'h0000_0000_00C0_0000);
      reset_dut(); start_dut();
      repeat (6) tick();
      chk("halt_pc", pc_out, 2);
      chk("halt_cnt", instr_cnt, 3);
      repeat (3) tick();
      chk("halt_holds", {halted, pc_out}, {1'b1, 3'd2});
      start_dut();
      chk("restart_busy", {busy, halted}, 2'b10);
      chk("restart_pc", pc_out, 0);
      chk("restart_cnt", instr_cnt, 0);
      tick(); tick();
      chk("restart_first", {pc_out, instr_cnt}, {3'd1, 8'd1});

      // Counter saturation in a JMP-to-self loop
      load_rom(64'h40);
      reset_dut(); start_dut();
      repeat (600) tick();
      chk("sat_cnt", instr_cnt, 255);
      chk("sat_busy", busy, 1);

      // Random programs against an instruction-level model
      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
         carry_in = 1'b0;
         reset_dut(); start_dut();
         mpc = 3'd0; mflag = 1'b0; mcnt = 0; mdone = 1'b0;
         for (int k = 0; k < 12 && !mdone; k++) begin
            carry_in = 1'($urandom);
            tick();
            w = rom[mpc];
            exp_ctl = (w[7:6] == 2'b00) ? w[3:0] : 4'h0;
            chk($sformatf("rnd%0d_%0d_exec_pc", p, k), pc_out, mpc);
            chk($sformatf("rnd%0d_%0d_ctl", p, k), {alu_sel, mux_sel, load}, exp_ctl);
            case (w[7:6])
               2'b00: begin
                  if (w[0]) mflag = carry_in;
                  mpc = mpc + 3'd1;
               end
               2'b01: mpc = w[2:0];
               2'b10: mpc = mflag ? w[2:0] : mpc + 3'd1;
               default: mdone = 1'b1;
            endcase
            mcnt = (mcnt == 255) ? 255 : mcnt + 1;
            tick();
            chk($sformatf("rnd%0d_%0d_pc", p, k), pc_out, mpc);
            chk($sformatf("rnd%0d_%0d_cnt", p, k), instr_cnt, mcnt);
            chk($sformatf("rnd%0d_%0d_halted", p, k), halted, mdone);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
